// File: rtl/window_3x3_builder_if.sv
// Pixel-stream handshake and window output bundle for window_3x3_builder.
// The master drives pixels and consumes windows; the slave is the builder itself.
interface window_3x3_builder_if #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic          in_valid;
  logic [11:0]   in_pixel;
  logic          in_sof;
  logic          in_ready;
  logic          out_valid;
  logic [107:0]  color_data;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_sof;
  logic          out_eof;

  modport master (
    output in_valid, in_pixel, in_sof,
    input  in_ready, out_valid, color_data, out_x, out_y, out_sof, out_eof
  );

  modport slave (
    input  in_valid, in_pixel, in_sof,
    output in_ready, out_valid, color_data, out_x, out_y, out_sof, out_eof
  );
endinterface

// File: rtl/window_3x3_builder.sv
// Builds zero-padded 3x3 RGB444 neighbourhoods from a raster pixel stream using
// two line buffers; self-flushes the trailing windows at end of frame.
module window_3x3_builder #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  window_3x3_builder_if.slave  bus
);
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = $clog2(NPIX + WIDTH + 2);
  localparam logic [XW-1:0] X_LAST      = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(HEIGHT - 1);
  localparam logic [CW-1:0] N_FILL_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] N_LAST      = CW'(NPIX - 1);
  localparam logic [CW-1:0] N_FLUSH_END = CW'(NPIX + WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [XW-1:0] in_x_q, cx_q;
  logic [YW-1:0] cy_q;
  logic [11:0]   lb0_q [WIDTH];
  logic [11:0]   lb1_q [WIDTH];
  logic [11:0]   top_q [3];
  logic [11:0]   mid_q [3];
  logic [11:0]   bot_q [3];

  logic          shift_s, emit_s, start_s, in_ready_d;
  logic [XW-1:0] addr_s;
  logic [11:0]   pix_s, up_new_s, mid_new_s;
  logic          lm_s, rm_s, um_s, dm_s;
  logic [107:0]  color_d;

  logic          in_ready_q, out_valid_q, out_sof_q, out_eof_q;
  logic [107:0]  color_q;
  logic [XW-1:0] out_x_q;
  logic [YW-1:0] out_y_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; an in_sof beat outside FLUSH always restarts the frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.in_valid && bus.in_sof) state_d = FILL; else state_d = IDLE;
      FILL: begin
        if (bus.in_valid && bus.in_sof)                   state_d = FILL;
        else if (bus.in_valid && (cnt_q == N_FILL_LAST)) state_d = RUN;
        else                                              state_d = FILL;
      end
      RUN: begin
        if (bus.in_valid && bus.in_sof)             state_d = FILL;
        else if (bus.in_valid && (cnt_q == N_LAST)) state_d = FLUSH;
        else                                        state_d = RUN;
      end
      FLUSH: if (cnt_q == N_FLUSH_END) state_d = IDLE; else state_d = FLUSH;
      default: state_d = IDLE;
    endcase
  end

  // Per-state datapath controls
  always_comb begin
    shift_s = 1'b0;
    emit_s  = 1'b0;
    start_s = 1'b0;
    case (state_q)
      IDLE: begin
        shift_s = bus.in_valid && bus.in_sof;
        start_s = bus.in_valid && bus.in_sof;
      end
      FILL: begin
        shift_s = bus.in_valid;
        start_s = bus.in_valid && bus.in_sof;
      end
      RUN: begin
        shift_s = bus.in_valid;
        start_s = bus.in_valid && bus.in_sof;
        emit_s  = bus.in_valid && !bus.in_sof;
      end
      FLUSH: begin
        shift_s = 1'b1;
        emit_s  = 1'b1;
      end
      default: begin
        shift_s = 1'b0;
        emit_s  = 1'b0;
        start_s = 1'b0;
      end
    endcase
    in_ready_d = (state_d != FLUSH);
  end

  // New right-hand column and the edge-masked window it completes
  always_comb begin
    addr_s    = start_s ? {XW{1'b0}} : in_x_q;
    pix_s     = (state_q == FLUSH) ? 12'd0 : bus.in_pixel;
    up_new_s  = lb0_q[addr_s];
    mid_new_s = lb1_q[addr_s];
    lm_s = (cx_q == {XW{1'b0}});
    rm_s = (cx_q == X_LAST);
    um_s = (cy_q == {YW{1'b0}});
    dm_s = (cy_q == Y_LAST);
    // Column masks also hide the previous/next row that raster wrap drags in
    color_d = {mid_q[2],
               lm_s          ? 12'd0 : mid_q[1],
               rm_s          ? 12'd0 : mid_new_s,
               um_s          ? 12'd0 : top_q[2],
               dm_s          ? 12'd0 : bot_q[2],
               (lm_s || um_s) ? 12'd0 : top_q[1],
               (rm_s || um_s) ? 12'd0 : up_new_s,
               (lm_s || dm_s) ? 12'd0 : bot_q[1],
               (rm_s || dm_s) ? 12'd0 : pix_s};
  end

  // Line buffers and 3x3 shift window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        lb0_q[i] <= 12'd0;
        lb1_q[i] <= 12'd0;
      end
      for (int j = 0; j < 3; j++) begin
        top_q[j] <= 12'd0;
        mid_q[j] <= 12'd0;
        bot_q[j] <= 12'd0;
      end
    end else if (shift_s) begin
      lb0_q[addr_s] <= mid_new_s;
      lb1_q[addr_s] <= pix_s;
      top_q[0] <= top_q[1]; top_q[1] <= top_q[2]; top_q[2] <= up_new_s;
      mid_q[0] <= mid_q[1]; mid_q[1] <= mid_q[2]; mid_q[2] <= mid_new_s;
      bot_q[0] <= bot_q[1]; bot_q[1] <= bot_q[2]; bot_q[2] <= pix_s;
    end
  end

  // Input index/column and centre coordinate counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= {CW{1'b0}};
      in_x_q <= {XW{1'b0}};
      cx_q   <= {XW{1'b0}};
      cy_q   <= {YW{1'b0}};
    end else begin
      if (start_s) begin
        cnt_q  <= CW'(1);
        in_x_q <= XW'(1);
      end else if (shift_s) begin
        cnt_q  <= cnt_q + CW'(1);
        in_x_q <= (in_x_q == X_LAST) ? {XW{1'b0}} : in_x_q + XW'(1);
      end
      if (start_s) begin
        cx_q <= {XW{1'b0}};
        cy_q <= {YW{1'b0}};
      end else if (emit_s) begin
        if (cx_q == X_LAST) begin
          cx_q <= {XW{1'b0}};
          cy_q <= (cy_q == Y_LAST) ? {YW{1'b0}} : cy_q + YW'(1);
        end else begin
          cx_q <= cx_q + XW'(1);
        end
      end
    end
  end

  // Registered outputs; window data holds between strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      color_q     <= 108'd0;
      out_x_q     <= {XW{1'b0}};
      out_y_q     <= {YW{1'b0}};
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= emit_s;
      out_sof_q   <= emit_s && lm_s && um_s;
      out_eof_q   <= emit_s && rm_s && dm_s;
      if (emit_s) begin
        color_q <= color_d;
        out_x_q <= cx_q;
        out_y_q <= cy_q;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.color_data = color_q;
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign bus.out_sof    = out_sof_q;
  assign bus.out_eof    = out_eof_q;
endmodule

// File: tb/tb_window_3x3_builder.sv
// Scoreboard bench for window_3x3_builder: directed test-plan frames plus
// randomized frames checked against a coordinate-based neighbourhood model.
module tb_window_3x3_builder;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NP = W * H;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_3x3_builder_if #(.WIDTH(W), .HEIGHT(H)) bus ();
  window_3x3_builder #(.WIDTH(W), .HEIGHT(H)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [107:0] data;
    logic [1:0]   x;
    logic [1:0]   y;
    logic         sof;
    logic         eof;
  } win_t;

  win_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           win_count = 0;
  logic [11:0]  frame [NP];
  logic [107:0] seen [NP];
  int           n = 0;
  bit           active = 1'b0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] px(int x, int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 12'd0;
    return frame[y * W + x];
  endfunction

  function automatic win_t model_win(int c);
    win_t w;
    int x, y;
    x = c % W;
    y = c / W;
    w.data = {px(x, y), px(x - 1, y), px(x + 1, y), px(x, y - 1), px(x, y + 1),
              px(x - 1, y - 1), px(x + 1, y - 1), px(x - 1, y + 1), px(x + 1, y + 1)};
    w.x   = 2'(x);
    w.y   = 2'(y);
    w.sof = (c == 0);
    w.eof = (c == NP - 1);
    return w;
  endfunction

  // A window is fully known once the pixel below-right of its centre arrives.
  task automatic model_accept(logic [11:0] pix, bit sof);
    if (sof) begin
      n = 0;
      active = 1'b1;
    end
    if (active) begin
      frame[n] = pix;
      if (n >= W + 1) exp_q.push_back(model_win(n - W - 1));
      if (n == NP - 1) begin
        for (int c = NP - W - 1; c < NP; c++) exp_q.push_back(model_win(c));
        active = 1'b0;
      end
      n++;
    end
  endtask

  task automatic send(logic [11:0] pix, bit sof);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pixel = pix;
    bus.in_sof   = sof;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got in_ready=%b expected 1", bus.in_ready);
    end else begin
      model_accept(pix, sof);
    end
    @(posedge clk);
  endtask

  task automatic idle(int k);
    repeat (k) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
    end
  endtask

  task automatic plan_frame(int gap_after);
    for (int i = 0; i < NP; i++) begin
      send(12'(i + 1), i == 0);
      if (i == gap_after) idle(3);
    end
  endtask

  task automatic check_window_count(string name, int start, int expect_n);
    check(name, 128'(win_count - start), 128'(expect_n));
  endtask

  // Monitor: every presented window must match the next expected one
  always @(posedge clk) begin
    win_t e;
    #1;
    if (bus.out_valid === 1'b1) begin
      win_count++;
      seen[int'(bus.out_y) * W + int'(bus.out_x)] = bus.color_data;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_window: got x=%0d y=%0d expected none", bus.out_x, bus.out_y);
      end else begin
        e = exp_q.pop_front();
        check("window_data", 128'(bus.color_data), 128'(e.data));
        check("window_pos", 128'({bus.out_x, bus.out_y, bus.out_sof, bus.out_eof}),
              128'({e.x, e.y, e.sof, e.eof}));
      end
    end
  end

  initial begin
    int start, lows, plen;
    logic [11:0] rpix;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_pixel = 12'd0;
    bus.in_sof   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 128'({bus.out_valid, bus.color_data, bus.out_x, bus.out_y,
                                  bus.out_sof, bus.out_eof}), 128'(0));
    check("reset_in_ready", 128'(bus.in_ready), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 128'(bus.in_ready), 128'(1));

    // Continuous frame with flush back-pressure measurement
    for (int i = 0; i < NP; i++) seen[i] = 108'd0;
    start = win_count;
    plan_frame(-1);
    lows = 0;
    repeat (8) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.in_ready !== 1'b1) lows++;
    end
    check("flush_ready_low", 128'(lows), 128'(W + 1));
    idle(3);
    check_window_count("frame_windows", start, NP);
    check("win_0_0", 128'(seen[0]), 128'({12'd1, 12'd0, 12'd2, 12'd0, 12'd5,
                                          12'd0, 12'd0, 12'd0, 12'd6}));
    check("win_3_1", 128'(seen[7]), 128'({12'd8, 12'd7, 12'd0, 12'd4, 12'd12,
                                          12'd3, 12'd0, 12'd11, 12'd0}));
    check("win_3_2", 128'(seen[11]), 128'({12'd12, 12'd11, 12'd0, 12'd8, 12'd0,
                                           12'd7, 12'd0, 12'd0, 12'd0}));

    // Stall mid-RUN
    start = win_count;
    plan_frame(7);
    idle(W + 4);
    check_window_count("stall_windows", start, NP);

    // Abort: frame A's 8th beat carries in_sof and starts frame B
    start = win_count;
    for (int i = 0; i < 7; i++) send(12'(100 + i), i == 0);
    plan_frame(-1);
    idle(W + 4);
    check_window_count("abort_windows", start, 2 + NP);

    // Pre-sof junk is discarded
    start = win_count;
    for (int i = 0; i < 5; i++) send(12'(200 + i), 1'b0);
    plan_frame(-1);
    idle(W + 4);
    check_window_count("junk_windows", start, NP);

    // Reset in the middle of FLUSH
    plan_frame(-1);
    idle(2);
    reset = 1'b1;
    exp_q.delete();
    active = 1'b0;
    @(negedge clk);
    check("flush_reset_outputs", 128'({bus.out_valid, bus.color_data, bus.out_x, bus.out_y,
                                        bus.out_sof, bus.out_eof}), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    check("flush_reset_ready", 128'(bus.in_ready), 128'(1));
    start = win_count;
    plan_frame(-1);
    idle(W + 4);
    check_window_count("post_reset_windows", start, NP);

    // Randomized frames: junk, optional aborted prefix, random gaps
    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(0, 2)) send(12'($urandom_range(0, 4095)), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        plen = $urandom_range(1, NP - 1);
        for (int i = 0; i < plen; i++) send(12'($urandom_range(0, 4095)), i == 0);
      end
      for (int i = 0; i < NP; i++) begin
        rpix = 12'($urandom_range(0, 4095));
        send(rpix, i == 0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, W + 3));
    end

    idle(20);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
